tiled_array_controller: RTL and testbench
=========================================

# tiled_array_controller

Sequencer for the PE array. It is the parametrised successor of the single-tile array controller. It accepts an arbitrary M×N output workload with K-deep accumulation and walks it over the NUM_ROWS×NUM_PEs_PER_ROW array tile by tile, in row-major tile order. On edge tiles it masks off the unused PEs, and it adds abort, error and done signalling. It sits between the host-side configuration registers and the PE_wrapper control inputs.

## Interface
Parameters:
- INT8, 8: base word width; size ports are 2*INT8 bits.
- NUM_ROWS, 5: PE rows in the array.
- NUM_PEs_PER_ROW, 5: PE columns per row.
- NUM_PES, NUM_ROWS*NUM_PEs_PER_ROW: width of per-PE masks. This is derived; do not override it.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_workLoad  in  1  capture M_size/N_size/K_size. Accepted only in IDLE.
- M_size, N_size, K_size  in  2*INT8 each  output rows, output columns, accumulation depth.
- configure  in  1  start-of-job strobe. Accepted only in IDLE.
- abort  in  1  synchronous cancel. Accepted in any state.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when the job completes.
- err  out  1  one-cycle pulse when configure is rejected.
- start_o  out  1  first compute cycle of each tile.
- ld_reg_o  out  1  operand-register load, one cycle per tile.
- clk_en_i  out  NUM_PES  per-PE clock enable.
- adder_en_i  out  NUM_PES  per-PE accumulate enable.
- visible_i  out  NUM_PES  per-PE output-visible (drain) enable.

## Operation
- PE index = r*NUM_PEs_PER_ROW + c, with r = row and c = column.
- Tiles: TR = ceil(M/NUM_ROWS) tile rows, TC = ceil(N/NUM_PEs_PER_ROW) tile columns. Order is tc fastest, then tr.
- Active rows for a tile: ar = min(NUM_ROWS, M − tr*NUM_ROWS).
- Active columns for a tile: ac = min(NUM_PEs_PER_ROW, N − tc*NUM_PEs_PER_ROW).
- Active mask: bit set iff r<ar and c<ac.
- Stored sizes: M, N and K are latched on load_workLoad in IDLE. They persist across jobs until the next load. load_workLoad in any other state is ignored.
- States:
  - IDLE: on configure, go to LOAD if M, N and K are all nonzero. Otherwise pulse err and stay in IDLE.
  - LOAD (1 cycle): ld_reg_o=1, then go to COMPUTE.
  - COMPUTE (K cycles):
    - clk_en_i = active mask on every cycle.
    - start_o=1 on the first cycle only.
    - adder_en_i = active mask on cycles 2..K and 0 on cycle 1 (K=1: never).
  - DRAIN (ar cycles): on cycle d, visible_i has bits set for row d, columns c<ac only.
  - After DRAIN: go to LOAD for the next tile if one remains, otherwise go to DONE.
  - DONE (1 cycle): done=1, then go to IDLE.
- busy=1 in LOAD, COMPUTE and DRAIN. busy=0 in IDLE and DONE.
- abort in any non-IDLE state: go to IDLE on the next edge. All outputs are 0 from that cycle; no done pulse. Tile counters clear; stored sizes are kept.
- abort and configure together in IDLE: abort wins, so the job does not start.
- Arithmetic:
  - Tile and drain counters are sized with $clog2 of the parameters.
  - The K counter is 2*INT8 bits.
  - ceil-div results are computed once in IDLE on configure and registered. No divider in the loop.

## Timing
- Every output is decoded from registered state and counters only. There is no combinational path from any input to any output.
- Reset (rst=0): state=IDLE, all counters and stored sizes =0, and every output =0 asynchronously.
- configure sampled at edge t:
  - LOAD is active in cycle t+1, with busy and ld_reg_o high.
  - The first start_o is in cycle t+2.
- Single-tile job: busy is high for 1+K+ar cycles. done follows in the next cycle.
- Multi-tile job: the busy length is the sum over tiles of (1+K+ar). There are no idle gaps between tiles.
- Reset asserted mid-job: immediate return to IDLE, with the same effect as power-on reset.

## Structure
- Shared header parameters.vh holds:
  - the state encodings (IDLE, LOAD, COMPUTE, DRAIN, DONE) as localparams;
  - the default array dimensions;
  - the size width 2*INT8.
- One sub-module, pe_mask_gen: combinational. It maps (ar, ac, drain_row, mode) to a NUM_PES-bit mask and is instantiated once.

## Test plan
- Full tile: M=N=5, K=3, configure.
  - ld_reg_o for 1 cycle.
  - start_o for 1 cycle; clk_en_i = all 25 bits set for 3 cycles.
  - adder_en_i = all 25 bits set for 2 cycles.
  - visible_i = 0x1F<<5d for d=0..4.
  - done in cycle 10 after configure; busy high for 9 cycles.
- Edge tiles: M=7, N=3, K=2.
  - Tile 0: clk_en_i has pattern 0b00111 in rows 0-4; drain runs 5 cycles.
  - Tile 1: clk_en_i has pattern 0b00111 in rows 0-1 only; drain runs 2 cycles.
  - busy high for 8+5=13 cycles, then done.
- Zero size: K=0, configure → err pulses 1 cycle, busy stays 0, no ld_reg_o.
- Abort: during COMPUTE of tile 2 in a 4-tile job, assert abort → next cycle all outputs 0 and state IDLE, no done. A new configure then restarts from tile 0.
- Load while busy: load_workLoad with M=1 mid-job is ignored. The job finishes with the original sizes, and the next configure reuses them.
- Reset mid-drain: rst=0 → all outputs 0 without waiting for an edge. After release, the block is idle and stored sizes read back as 0 (configure → err).

Source files
------------

// File: rtl/tiled_array_controller_pkg.sv
// Shared types and defaults for the tiled PE-array sequencer: FSM state encoding,
// mask-generator modes, default array dimensions and the size word width.
package tiled_array_controller_pkg;

    localparam int unsigned DefInt8    = 8;
    localparam int unsigned DefNumRows = 5;
    localparam int unsigned DefNumCols = 5;
    localparam int unsigned DefSizeW   = 2 * DefInt8;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StCompute = 3'd2,
        StDrain   = 3'd3,
        StDone    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MaskOff    = 2'd0,
        MaskActive = 2'd1,
        MaskDrain  = 2'd2
    } mask_mode_e;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/tiled_array_controller_if.sv
// Host/PE-side signal bundle of the tiled array controller; master drives the
// workload and strobes, slave (the controller) drives status and PE controls.
interface tiled_array_controller_if #(
    parameter int unsigned INT8            = 8,
    parameter int unsigned NUM_ROWS        = 5,
    parameter int unsigned NUM_PEs_PER_ROW = 5
);
    localparam int unsigned NUM_PES = NUM_ROWS * NUM_PEs_PER_ROW;

    logic                load_workLoad;
    logic [2*INT8-1:0]   M_size;
    logic [2*INT8-1:0]   N_size;
    logic [2*INT8-1:0]   K_size;
    logic                configure;
    logic                abort;
    logic                busy;
    logic                done;
    logic                err;
    logic                start_o;
    logic                ld_reg_o;
    logic [NUM_PES-1:0]  clk_en_i;
    logic [NUM_PES-1:0]  adder_en_i;
    logic [NUM_PES-1:0]  visible_i;

    modport master (
        output load_workLoad, M_size, N_size, K_size, configure, abort,
        input  busy, done, err, start_o, ld_reg_o, clk_en_i, adder_en_i, visible_i
    );

    modport slave (
        input  load_workLoad, M_size, N_size, K_size, configure, abort,
        output busy, done, err, start_o, ld_reg_o, clk_en_i, adder_en_i, visible_i
    );

endinterface

// File: rtl/tiled_array_controller_pe_mask_gen.sv
// Combinational per-PE mask: the ar x ac active rectangle, or one row of it while
// draining. Bit index is row * NUM_PEs_PER_ROW + column.
module pe_mask_gen
    import tiled_array_controller_pkg::*;
#(
    parameter int unsigned NUM_ROWS        = 5,
    parameter int unsigned NUM_PEs_PER_ROW = 5,
    parameter int unsigned ARW             = 3,
    parameter int unsigned ACW             = 3,
    parameter int unsigned DRW             = 3
) (
    input  logic [ARW-1:0]                          i_ar,
    input  logic [ACW-1:0]                          i_ac,
    input  logic [DRW-1:0]                          i_drain_row,
    input  mask_mode_e                              i_mode,
    output logic [NUM_ROWS*NUM_PEs_PER_ROW-1:0]     o_mask
);

    always_comb begin
        o_mask = '0;
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            for (int c = 0; c < int'(NUM_PEs_PER_ROW); c++) begin
                if ((ARW'(r) < i_ar) && (ACW'(c) < i_ac)) begin
                    if (i_mode == MaskActive) begin
                        o_mask[r*NUM_PEs_PER_ROW+c] = 1'b1;
                    end else if ((i_mode == MaskDrain) && (DRW'(r) == i_drain_row)) begin
                        o_mask[r*NUM_PEs_PER_ROW+c] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tiled_array_controller.sv
// Walks an M x N (K-deep) workload over the PE array tile by tile, row-major,
// masking unused PEs on edge tiles. All outputs decode registered state only.
module tiled_array_controller
    import tiled_array_controller_pkg::*;
#(
    parameter int unsigned  INT8            = DefInt8,
    parameter int unsigned  NUM_ROWS        = DefNumRows,
    parameter int unsigned  NUM_PEs_PER_ROW = DefNumCols,
    localparam int unsigned NUM_PES         = NUM_ROWS * NUM_PEs_PER_ROW
) (
    input logic                     clk,
    input logic                     rst,
    tiled_array_controller_if.slave bus
);

    localparam int unsigned SW  = 2 * INT8;
    localparam int unsigned TRW = $clog2(ceil_div(2 ** SW, NUM_ROWS) + 1);
    localparam int unsigned TCW = $clog2(ceil_div(2 ** SW, NUM_PEs_PER_ROW) + 1);
    localparam int unsigned ARW = $clog2(NUM_ROWS + 1);
    localparam int unsigned ACW = $clog2(NUM_PEs_PER_ROW + 1);
    localparam int unsigned DRW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    state_e             r_state, w_state_nxt;
    logic [SW-1:0]      r_m, r_n, r_k;
    logic [SW-1:0]      r_m_rem, r_n_rem;
    logic [SW-1:0]      r_kcnt;
    logic [TRW-1:0]     r_tr, r_tr_last;
    logic [TCW-1:0]     r_tc, r_tc_last;
    logic [DRW-1:0]     r_dcnt;
    logic               r_err;

    logic [ARW-1:0]     w_ar;
    logic [ACW-1:0]     w_ac;
    logic               w_sizes_ok, w_k_last, w_drain_last, w_last_tile;
    mask_mode_e         w_mode;
    logic [NUM_PES-1:0] w_mask;

    // Remaining rows/columns are tracked by subtraction so no multiply sits in the loop.
    assign w_ar = (r_m_rem >= SW'(NUM_ROWS)) ? ARW'(NUM_ROWS) : ARW'(r_m_rem);
    assign w_ac = (r_n_rem >= SW'(NUM_PEs_PER_ROW)) ? ACW'(NUM_PEs_PER_ROW) : ACW'(r_n_rem);

    assign w_sizes_ok   = (r_m != '0) && (r_n != '0) && (r_k != '0);
    assign w_k_last     = (r_kcnt == r_k - SW'(1));
    assign w_drain_last = (ARW'(r_dcnt) == w_ar - ARW'(1));
    assign w_last_tile  = (r_tr == r_tr_last) && (r_tc == r_tc_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:    if (bus.configure && w_sizes_ok) w_state_nxt = StLoad;
            StLoad:    w_state_nxt = StCompute;
            StCompute: if (w_k_last) w_state_nxt = StDrain;
            StDrain:   if (w_drain_last) w_state_nxt = w_last_tile ? StDone : StLoad;
            StDone:    w_state_nxt = StIdle;
            default:   w_state_nxt = StIdle;
        endcase
        if (bus.abort) w_state_nxt = StIdle;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m       <= '0;
            r_n       <= '0;
            r_k       <= '0;
            r_m_rem   <= '0;
            r_n_rem   <= '0;
            r_kcnt    <= '0;
            r_tr      <= '0;
            r_tr_last <= '0;
            r_tc      <= '0;
            r_tc_last <= '0;
            r_dcnt    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (bus.abort) begin
                r_tr   <= '0;
                r_tc   <= '0;
                r_kcnt <= '0;
                r_dcnt <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (bus.load_workLoad) begin
                            r_m <= bus.M_size;
                            r_n <= bus.N_size;
                            r_k <= bus.K_size;
                        end
                        if (bus.configure) begin
                            if (w_sizes_ok) begin
                                r_tr_last <= TRW'(ceil_div(32'(r_m), NUM_ROWS) - 1);
                                r_tc_last <= TCW'(ceil_div(32'(r_n), NUM_PEs_PER_ROW) - 1);
                                r_tr      <= '0;
                                r_tc      <= '0;
                                r_m_rem   <= r_m;
                                r_n_rem   <= r_n;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    StLoad:    r_kcnt <= '0;
                    StCompute: begin
                        r_kcnt <= r_kcnt + SW'(1);
                        r_dcnt <= '0;
                    end
                    StDrain: begin
                        if (w_drain_last) begin
                            r_dcnt <= '0;
                            if (r_tc == r_tc_last) begin
                                r_tc    <= '0;
                                r_n_rem <= r_n;
                                r_tr    <= r_tr + TRW'(1);
                                r_m_rem <= r_m_rem - SW'(NUM_ROWS);
                            end else begin
                                r_tc    <= r_tc + TCW'(1);
                                r_n_rem <= r_n_rem - SW'(NUM_PEs_PER_ROW);
                            end
                        end else begin
                            r_dcnt <= r_dcnt + DRW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_mode = MaskOff;
        if (r_state == StCompute) w_mode = MaskActive;
        else if (r_state == StDrain) w_mode = MaskDrain;
    end

    pe_mask_gen #(
        .NUM_ROWS        (NUM_ROWS),
        .NUM_PEs_PER_ROW (NUM_PEs_PER_ROW),
        .ARW             (ARW),
        .ACW             (ACW),
        .DRW             (DRW)
    ) u_pe_mask_gen (
        .i_ar        (w_ar),
        .i_ac        (w_ac),
        .i_drain_row (r_dcnt),
        .i_mode      (w_mode),
        .o_mask      (w_mask)
    );

    assign bus.busy       = (r_state == StLoad) || (r_state == StCompute) || (r_state == StDrain);
    assign bus.done       = (r_state == StDone);
    assign bus.err        = r_err;
    assign bus.ld_reg_o   = (r_state == StLoad);
    assign bus.start_o    = (r_state == StCompute) && (r_kcnt == '0);
    assign bus.clk_en_i   = (r_state == StCompute) ? w_mask : '0;
    assign bus.adder_en_i = ((r_state == StCompute) && (r_kcnt != '0)) ? w_mask : '0;
    assign bus.visible_i  = (r_state == StDrain) ? w_mask : '0;

endmodule

// File: tb/tb_tiled_array_controller.sv
// Scoreboard bench: each job's cycle-by-cycle outputs are predicted from the tiling
// rules and queued; a negedge monitor pops and compares whenever the DUT is active.
module tb_tiled_array_controller;

    localparam int unsigned R  = 5;
    localparam int unsigned C  = 5;
    localparam int unsigned NP = R * C;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          err;
        logic          start;
        logic          ld;
        logic [NP-1:0] clk_en;
        logic [NP-1:0] adder;
        logic [NP-1:0] vis;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   st_m = 0, st_n = 0, st_k = 0;
    ev_t  exp_q[$];
    ev_t  job_q[$];

    tiled_array_controller_if #(.INT8(8), .NUM_ROWS(R), .NUM_PEs_PER_ROW(C)) bus ();

    tiled_array_controller #(
        .INT8            (8),
        .NUM_ROWS        (R),
        .NUM_PEs_PER_ROW (C)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic ev_t sample();
        ev_t s;
        s.busy   = bus.busy;
        s.done   = bus.done;
        s.err    = bus.err;
        s.start  = bus.start_o;
        s.ld     = bus.ld_reg_o;
        s.clk_en = bus.clk_en_i;
        s.adder  = bus.adder_en_i;
        s.vis    = bus.visible_i;
        return s;
    endfunction

    task automatic check_int(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_ev(input string name, input ev_t got, input ev_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Expected activity of one job, built straight from the tile walk.
    function automatic void build_job(input int m, input int n, input int k);
        ev_t e;
        job_q.delete();
        if (m == 0 || n == 0 || k == 0) begin
            e = '0;
            e.err = 1'b1;
            job_q.push_back(e);
            return;
        end
        for (int tr = 0; tr * int'(R) < m; tr++) begin
            for (int tc = 0; tc * int'(C) < n; tc++) begin
                int            ar;
                int            ac;
                logic [NP-1:0] act;
                ar  = (m - tr * int'(R) < int'(R)) ? m - tr * int'(R) : int'(R);
                ac  = (n - tc * int'(C) < int'(C)) ? n - tc * int'(C) : int'(C);
                act = '0;
                for (int r = 0; r < ar; r++)
                    for (int c = 0; c < ac; c++) act[r*int'(C)+c] = 1'b1;
                e = '0; e.busy = 1'b1; e.ld = 1'b1;
                job_q.push_back(e);
                for (int i = 0; i < k; i++) begin
                    e = '0; e.busy = 1'b1; e.clk_en = act;
                    e.start = (i == 0);
                    e.adder = (i == 0) ? '0 : act;
                    job_q.push_back(e);
                end
                for (int d = 0; d < ar; d++) begin
                    e = '0; e.busy = 1'b1;
                    for (int c = 0; c < ac; c++) e.vis[d*int'(C)+c] = 1'b1;
                    job_q.push_back(e);
                end
            end
        end
        e = '0; e.done = 1'b1;
        job_q.push_back(e);
    endfunction

    // Monitor: every active cycle must match the head of the expectation queue.
    initial begin
        ev_t g;
        ev_t w;
        int  idx = 0;
        forever begin
            @(negedge clk);
            g = sample();
            if (rst && (g !== '0)) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, expected idle", g);
                end else begin
                    w = exp_q.pop_front();
                    check_ev($sformatf("cycle_%0d", idx), g, w);
                end
                idx++;
            end
        end
    end

    task automatic load(input int m, input int n, input int k);
        @(posedge clk); #1;
        bus.load_workLoad = 1'b1;
        bus.M_size = 16'(m);
        bus.N_size = 16'(n);
        bus.K_size = 16'(k);
        @(posedge clk); #1;
        bus.load_workLoad = 1'b0;
        st_m = m; st_n = n; st_k = k;
    endtask

    task automatic wait_empty();
        int budget = 3000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check_int("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
    endtask

    // abort_at: -1 none, -2 random, else index of the last active cycle before abort.
    task automatic run_job(input int abort_at, input bit poke, output int busy_len,
                           output int done_cyc);
        int a;
        int n;
        int bl;
        int dc;
        bit ok;
        ok = (st_m != 0) && (st_n != 0) && (st_k != 0);
        build_job(st_m, st_n, st_k);
        a = abort_at;
        if (a == -2) a = $urandom_range(0, job_q.size() - 2);
        if (!ok) a = -1;
        n = (a >= 0) ? a + 1 : job_q.size();
        for (int i = 0; i < n; i++) exp_q.push_back(job_q[i]);
        bl = 0;
        dc = -1;
        @(posedge clk); #1 bus.configure = 1'b1;
        @(posedge clk); #1 bus.configure = 1'b0;
        fork
            begin
                if (ok && a < 0) begin
                    for (int cyc = 1; cyc <= job_q.size() + 20 && dc < 0; cyc++) begin
                        @(negedge clk);
                        if (bus.busy) bl++;
                        if (bus.done) dc = cyc;
                    end
                    if (dc < 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL done_timeout: got no done, expected one");
                    end
                end
            end
            begin
                if (a >= 0) begin
                    repeat (a) @(posedge clk);
                    #1 bus.abort = 1'b1;
                    @(posedge clk); #1 bus.abort = 1'b0;
                end
                if (poke) begin
                    @(posedge clk); #1;
                    bus.load_workLoad = 1'b1;
                    bus.M_size = 16'd1; bus.N_size = 16'd1; bus.K_size = 16'd1;
                    @(posedge clk); #1 bus.load_workLoad = 1'b0;
                end
            end
        join
        wait_empty();
        busy_len = bl;
        done_cyc = dc;
    endtask

    initial begin
        int bl;
        int dc;
        bus.load_workLoad = 1'b0;
        bus.M_size = '0; bus.N_size = '0; bus.K_size = '0;
        bus.configure = 1'b0;
        bus.abort = 1'b0;
        #2 check_ev("reset_state", sample(), '0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk) check_ev("idle_after_reset", sample(), '0);

        load(5, 5, 3);
        run_job(-1, 1'b0, bl, dc);
        check_int("full_tile_busy", bl, 9);
        check_int("full_tile_done", dc, 10);

        load(7, 3, 2);
        run_job(-1, 1'b0, bl, dc);
        check_int("edge_tiles_busy", bl, 13);
        check_int("edge_tiles_done", dc, 14);

        load(5, 5, 0);
        run_job(-1, 1'b0, bl, dc);

        // Four tiles of 9 cycles; index 20 is inside tile 2's compute phase.
        load(10, 10, 3);
        run_job(20, 1'b0, bl, dc);
        run_job(-1, 1'b0, bl, dc);
        check_int("restart_busy", bl, 36);
        check_int("restart_done", dc, 37);

        @(posedge clk); #1 bus.abort = 1'b1; bus.configure = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0; bus.configure = 1'b0;
        @(negedge clk) check_ev("abort_beats_configure", sample(), '0);

        load(7, 3, 2);
        run_job(-1, 1'b1, bl, dc);
        check_int("load_while_busy_busy", bl, 13);
        run_job(-1, 1'b0, bl, dc);
        check_int("sizes_reused_busy", bl, 13);

        for (int j = 0; j < 10; j++) begin
            load($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(0, 6));
            run_job(($urandom_range(0, 3) == 0) ? -2 : -1, 1'b0, bl, dc);
        end

        // Reset in the middle of tile 0's drain (cycle index 5 of the job).
        load(7, 3, 2);
        build_job(st_m, st_n, st_k);
        for (int i = 0; i < 5; i++) exp_q.push_back(job_q[i]);
        @(posedge clk); #1 bus.configure = 1'b1;
        @(posedge clk); #1 bus.configure = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_ev("reset_async", sample(), '0);
        check_int("reset_consumed_queue", exp_q.size(), 0);
        @(posedge clk); #1 rst = 1'b1;
        st_m = 0; st_n = 0; st_k = 0;
        @(negedge clk) check_ev("idle_after_mid_reset", sample(), '0);
        run_job(-1, 1'b0, bl, dc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
